// File: rtl/pipe_stage_reg.sv
// Purpose : two-entry skid-buffered pipeline stage with flush-to-bubble (NOP_VAL); optional
//           stall/flush statistics counters when PIPE_STAGE_STATS_EN is defined.
// Latency : one cycle from accept to out_data when the stage is empty or drained on the same edge.
// Backpr. : in_ready is registered (low only when both entries are full); no combinational out_ready path.
module pipe_stage_reg #(
    parameter int                 DATA_W  = 32,
    parameter logic [DATA_W-1:0]  NOP_VAL = '0
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              accept;
    logic              take;

    // Handshakes use the registered ready/valid so neither depends on the opposite side combinationally.
    assign accept   = in_valid & in_ready;
    assign take     = out_valid & out_ready;
    assign out_data = main_q;

    // Occupancy FSM: payload storage plus registered out_valid/in_ready derived from the next state.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= EMPTY;
            main_q    <= NOP_VAL;
            skid_q    <= NOP_VAL;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else if (flush) begin
            // Flush wins over everything; a concurrent take is simply consumed, a concurrent accept is lost.
            state     <= EMPTY;
            main_q    <= NOP_VAL;
            skid_q    <= NOP_VAL;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state     <= ONE;
                        main_q    <= in_data;
                        out_valid <= 1'b1;
                        in_ready  <= 1'b1;
                    end
                end
                ONE: begin
                    if (accept && take) begin
                        main_q <= in_data;
                    end else if (accept) begin
                        state    <= TWO;
                        skid_q   <= in_data;
                        in_ready <= 1'b0;
                    end else if (take) begin
                        // Drained: return to the bubble encoding so out_data is NOP while invalid.
                        state     <= EMPTY;
                        main_q    <= NOP_VAL;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                TWO: begin
                    if (take) begin
                        state    <= ONE;
                        main_q   <= skid_q;
                        skid_q   <= NOP_VAL;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    main_q    <= NOP_VAL;
                    skid_q    <= NOP_VAL;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    // Saturating statistics; only reset clears them, flush does not.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            if (out_valid && !out_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (flush && (state != EMPTY) && (flush_cnt != 32'hFFFF_FFFF)) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32, payload width in bits (packed control plus datapath fields of one stage).
REQ-002 Parameter NOP_VAL, default all-zero DATA_W vector, payload loaded on reset and flush (bubble encoding).
REQ-003 Port CLK  input  1  rising-edge clock.
REQ-004 Port nRST  input  1  asynchronous active-low reset.
REQ-005 Port flush  input  1  discard all held and incoming payloads this cycle.
REQ-006 Port in_valid  input  1  upstream stage presents a payload.
REQ-007 Port in_ready  output  1  stage accepts a payload this cycle.
REQ-008 Port in_data  input  DATA_W  upstream payload.
REQ-009 Port out_valid  output  1  out_data holds a live payload.
REQ-010 Port out_ready  input  1  downstream consumes out_data this cycle.
REQ-011 Port out_data  output  DATA_W  payload to downstream stage.
REQ-012 Ports stall_cnt and flush_cnt  output  32 each  statistics, present only per REQ-027.

Function
REQ-013 Stage SHALL hold up to two payloads: main register (drives out_data) and skid register.
REQ-014 State machine SHALL have states EMPTY (0 held), ONE (main valid), TWO (main and skid valid).
REQ-015 out_valid SHALL be 1 exactly when state is not EMPTY, and out_data SHALL equal the main register.
REQ-016 in_ready SHALL be a registered output, 1 exactly when state is not TWO, with no combinational path from out_ready.
REQ-017 Accept = in_valid & in_ready; take = out_valid & out_ready; both evaluated at the rising edge.
REQ-018 EMPTY: accept -> ONE, main <= in_data; no accept -> stay EMPTY.
REQ-019 ONE: accept & take -> ONE, main <= in_data; accept only -> TWO, skid <= in_data; take only -> EMPTY; neither -> hold.
REQ-020 TWO: take -> ONE, main <= skid; no take -> hold; in_data ignored.
REQ-021 Latency SHALL be one cycle: a payload accepted at edge N appears on out_data after edge N when the stage was EMPTY or taken at N.
REQ-022 Payload order SHALL be strictly FIFO; no payload dropped or duplicated except per REQ-023.
REQ-023 flush=1 SHALL take priority over all other events: next state EMPTY, main and skid <= NOP_VAL, a concurrent accept discarded.
REQ-024 A concurrent take during flush SHALL count as consumed; the stage SHALL NOT re-present that payload.
REQ-025 While out_valid=0, out_data SHALL equal NOP_VAL.

Reset
REQ-026 nRST low SHALL asynchronously force state EMPTY, main and skid = NOP_VAL, out_valid=0, in_ready=1, counters 0; operation resumes on the first edge after release.

Configuration
REQ-027 Macro PIPE_STAGE_STATS_EN defined: stall_cnt increments each cycle out_valid=1 and out_ready=0; flush_cnt increments each cycle flush=1 and state is not EMPTY; both saturate at 0xFFFFFFFF; neither is cleared by flush.
REQ-028 PIPE_STAGE_STATS_EN undefined: stall_cnt, flush_cnt ports and counter logic SHALL be absent; all other behaviour is identical.

Verification
REQ-029 Streaming: out_ready=1, in_valid=1 for 8 cycles with data 1..8 -> out_data 1..8 on consecutive cycles starting one cycle after the first accept, in_ready constantly 1.
REQ-030 Backpressure: accept 0xA then 0xB with out_ready=0 -> state TWO, in_ready=0, out_data=0xA; raise out_ready -> 0xA then 0xB delivered, in_ready returns to 1 one cycle after the first take.
REQ-031 Flush in TWO with in_valid=1, in_data=0xC -> next cycle out_valid=0, out_data=NOP_VAL, in_ready=1; 0xC never appears.
REQ-032 Reset mid-operation: nRST low asynchronously while in TWO -> out_valid=0 and in_ready=1 before the next edge; first payload after release delivered normally.
REQ-033 With PIPE_STAGE_STATS_EN: hold out_valid=1, out_ready=0 for 5 cycles, then one flush on a non-empty stage -> stall_cnt=5, flush_cnt=1; preload stall_cnt at 0xFFFFFFFF -> stays 0xFFFFFFFF.
